// File: rtl/alu_seq_unit.sv
// Registered arithmetic unit with valid/ready handshakes. Single-cycle ops 0-3 plus an
// iterative shift-add multiply (op4); ovf/err status flags. One transaction in flight.
module alu_seq_unit #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] O,
    output logic             ovf,
    output logic             err
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     res;
    logic [WIDTH-1:0]     t;
    logic                 accept;
    logic                 is_mul;
    logic                 last;

    assign in_ready = (state == IDLE) | ((state == HOLD) & out_ready);
    assign accept   = in_valid & in_ready;
    assign is_mul   = (op == 3'd4);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign acc_nxt  = mplier[cnt] ? acc + (mcand << cnt) : acc;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    always_comb begin
        t   = (A << 1) - B;
        res = '0;
        case (op)
            3'd0:    res = (A << 2) + (B >> 1);
            3'd1:    res = A + B + (B << 1);
            3'd2:    res = WIDTH'(0) - B;
            3'd3:    res = t[WIDTH-1] ? WIDTH'(0) - t : t;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            O         <= '0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= MUL;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            acc       <= '0;
                            mcand     <= {{WIDTH{1'b0}}, A};
                            mplier    <= B;
                        end else begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            O         <= res;
                            ovf       <= 1'b0;
                            err       <= (op > 3'd4);
                        end
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    // Final iteration: publish straight from the adder output.
                    if (last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        O         <= acc_nxt[WIDTH-1:0];
                        ovf       <= |acc_nxt[2*WIDTH-1:WIDTH];
                        err       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (WIDTH=6): expected results queued at accept,
// compared when the unit hands a result to the consumer.
module tb_alu_seq_unit;
    localparam int W = 6;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] O;
    logic         ovf;
    logic         err;

    typedef struct packed {
        logic [W-1:0] o;
        logic         ovf;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .O(O), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic exp_t model(input int o_, input int a, input int b);
        exp_t e;
        int   x;
        e.ovf = 1'b0;
        e.err = 1'b0;
        case (o_)
            0: e.o = W'((a * 4 + b / 2) % M);
            1: e.o = W'((a + 3 * b) % M);
            2: e.o = W'((M - b) % M);
            3: begin
                x = ((2 * a - b) % M + M) % M;
                e.o = W'((x >= M / 2) ? (M - x) % M : x);
            end
            4: begin
                x = a * b;
                e.o = W'(x % M);
                e.ovf = (x >= M);
            end
            default: begin
                e.o = '0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Consumer side: a result is taken on the posedge following this sample.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = sb.pop_front();
                chk("O", O, e.o);
                chk("ovf", ovf, e.ovf);
                chk("err", err, e.err);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input int o_, input int a, input int b);
        int k;
        in_valid = 1'b1;
        op = 3'(o_);
        A = W'(a);
        B = W'(b);
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(model(o_, a, b));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic mul_lat(input int a, input int b);
        int c;
        bit irbad;
        c = 0;
        irbad = 1'b0;
        send(4, a, b);
        chk("mul_vld_low", out_valid, 0);
        while (c < 20) begin
            @(posedge clk);
            #1;
            c++;
            if (out_valid) break;
            if (in_ready) irbad = 1'b1;
        end
        chk("mul_latency", c, W);
        chk("mul_in_ready_low", irbad, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", out_valid, 0);
        chk("rst_O", O, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single-cycle ops
        send(0, 5, 9);
        chk("lat_op0", out_valid, 1);
        send(1, 10, 20);
        chk("lat_op1", out_valid, 1);
        drain();
        send(2, 0, 1);
        send(3, 3, 10);
        send(3, 20, 3);
        send(3, 16, 0);
        drain();

        // multiply latency and overflow
        mul_lat(7, 9);
        mul_lat(9, 9);
        mul_lat(63, 63);
        drain();

        // backpressure, then back-to-back handoff
        out_ready = 1'b0;
        send(1, 10, 20);
        for (int i = 0; i < 5; i++) begin
            A = W'($urandom);
            B = W'($urandom);
            op = 3'($urandom);
            @(posedge clk);
            #1;
            chk("bp_vld", out_valid, 1);
            chk("bp_O", O, 6);
            chk("bp_flags", {ovf, err}, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send(0, 5, 9);
        chk("b2b_vld", out_valid, 1);
        chk("b2b_O", O, 24);
        drain();

        // reserved op, then err clears
        send(6, 1, 1);
        send(1, 2, 3);
        drain();

        // zero operands on every op, then a random mix
        for (int o = 0; o < 8; o++) send(o, 0, 0);
        drain();
        for (int i = 0; i < 20; i++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, M - 1)),
                 int'($urandom_range(0, M - 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // asynchronous reset in the middle of a multiply
        send(0, 5, 9);
        drain();
        send(4, 5, 5);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_mul_vld", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_O", O, 0);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        send(0, 1, 2);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
